// File: rtl/fpu_add_sub_pkg.sv
// Shared constants and result record for the FPU add/sub datapath.
// The normalise record is reused by the exponent-adjust and packing stages.
package fpu_add_sub_pkg;

    localparam int SIZE_EXP  = 8;
    localparam int SIZE_MAN  = 23;
    localparam int SIZE_SUM  = SIZE_MAN + 2;
    localparam int SIZE_LOPD = 8;

    typedef struct packed {
        logic                 sign;
        logic [SIZE_EXP-1:0]  exp;
        logic [SIZE_LOPD-1:0] lopd;
        logic                 overflow;
        logic                 underflow;
        logic                 zero;
        logic [SIZE_MAN-1:0]  mant;
    } norm_result_t;

endpackage

// File: rtl/add_sub_mant_normalize_if.sv
// Upstream/downstream handshake and data bundle of the mantissa normalise stage.
// The slave modport is the stage's view; master is the surrounding datapath.
interface add_sub_mant_normalize_if #(
    parameter int SIZE_EXP  = fpu_add_sub_pkg::SIZE_EXP,
    parameter int SIZE_MAN  = fpu_add_sub_pkg::SIZE_MAN,
    parameter int SIZE_LOPD = fpu_add_sub_pkg::SIZE_LOPD
) ();
    localparam int SIZE_SUM = SIZE_MAN + 2;

    logic                 i_valid;
    logic                 o_ready;
    logic                 i_sign;
    logic [SIZE_EXP-1:0]  i_exp_value;
    logic [SIZE_SUM-1:0]  i_sum;
    logic                 o_valid;
    logic                 i_ready;
    logic                 o_sign;
    logic [SIZE_EXP-1:0]  o_exp_value;
    logic [SIZE_LOPD-1:0] o_lopd_value;
    logic                 o_overflow;
    logic                 o_underflow;
    logic                 o_zero_flag;
    logic [SIZE_MAN-1:0]  o_mant;

    modport slave (
        input  i_valid, i_sign, i_exp_value, i_sum, i_ready,
        output o_ready, o_valid, o_sign, o_exp_value, o_lopd_value,
               o_overflow, o_underflow, o_zero_flag, o_mant
    );

    modport master (
        output i_valid, i_sign, i_exp_value, i_sum, i_ready,
        input  o_ready, o_valid, o_sign, o_exp_value, o_lopd_value,
               o_overflow, o_underflow, o_zero_flag, o_mant
    );

endinterface

// File: rtl/add_sub_lopd.sv
// Combinational leading-one detector: number of zeros above the first set bit
// of i_vec, plus an all-zero flag (count is 0 when i_vec is zero).
module add_sub_lopd #(
    parameter int W  = 24,
    parameter int CW = 8
) (
    input  logic [W-1:0]  i_vec,
    output logic [CW-1:0] o_count,
    output logic          o_zero
);

    // Scanning upward lets the highest set bit overwrite lower ones.
    always_comb begin
        o_count = '0;
        for (int i = 0; i < W; i++) begin
            if (i_vec[i]) begin
                o_count = CW'(W - 1 - i);
            end
        end
    end

    assign o_zero = ~|i_vec;

endmodule

// File: rtl/add_sub_mant_normalize.sv
// Two-stage normalise stage: stage 1 finds the leading one and classifies,
// stage 2 shifts the mantissa and registers the flags for exponent adjust.
module add_sub_mant_normalize #(
    parameter int SIZE_EXP  = fpu_add_sub_pkg::SIZE_EXP,
    parameter int SIZE_MAN  = fpu_add_sub_pkg::SIZE_MAN,
    parameter int SIZE_LOPD = fpu_add_sub_pkg::SIZE_LOPD
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    add_sub_mant_normalize_if.slave  bus
);

    localparam int SIZE_SUM = SIZE_MAN + 2;
    localparam int CMP_W    = (SIZE_LOPD > SIZE_EXP) ? SIZE_LOPD : SIZE_EXP;

    logic                 s1_adv, s2_adv;
    logic [SIZE_LOPD-1:0] lz_raw;
    logic                 frac_zero;

    logic                 s1_valid_q, s1_valid_d;
    logic                 s1_sign_q,  s1_sign_d;
    logic [SIZE_EXP-1:0]  s1_exp_q,   s1_exp_d;
    logic [SIZE_SUM-1:0]  s1_sum_q,   s1_sum_d;
    logic                 s1_ovf_q,   s1_ovf_d;
    logic                 s1_zero_q,  s1_zero_d;
    logic [SIZE_LOPD-1:0] s1_lz_q,    s1_lz_d;

    logic                 o_valid_q,  o_valid_d;
    logic                 o_sign_q,   o_sign_d;
    logic [SIZE_EXP-1:0]  o_exp_q,    o_exp_d;
    logic [SIZE_LOPD-1:0] o_lopd_q,   o_lopd_d;
    logic                 o_ovf_q,    o_ovf_d;
    logic                 o_unf_q,    o_unf_d;
    logic                 o_zero_q,   o_zero_d;
    logic [SIZE_MAN-1:0]  o_mant_q,   o_mant_d;

    logic [SIZE_MAN-1:0]  norm_mant;
    logic                 unf_c;

    assign s2_adv      = ~o_valid_q | bus.i_ready;
    assign s1_adv      = ~s1_valid_q | s2_adv;
    assign bus.o_ready = s1_adv;

    add_sub_lopd #(
        .W  (SIZE_SUM - 1),
        .CW (SIZE_LOPD)
    ) u_lopd (
        .i_vec   (bus.i_sum[SIZE_SUM-2:0]),
        .o_count (lz_raw),
        .o_zero  (frac_zero)
    );

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_sign_d  = s1_sign_q;
        s1_exp_d   = s1_exp_q;
        s1_sum_d   = s1_sum_q;
        s1_ovf_d   = s1_ovf_q;
        s1_zero_d  = s1_zero_q;
        s1_lz_d    = s1_lz_q;
        if (s1_adv) begin
            s1_valid_d = bus.i_valid;
            s1_sign_d  = bus.i_sign;
            s1_exp_d   = bus.i_exp_value;
            s1_sum_d   = bus.i_sum;
            s1_ovf_d   = bus.i_sum[SIZE_SUM-1];
            s1_zero_d  = ~bus.i_sum[SIZE_SUM-1] & frac_zero;
            s1_lz_d    = lz_raw;
        end
    end

    // Shifting by lz puts the leading one in the hidden position; the
    // truncation keeps only the fraction below it.
    assign norm_mant = SIZE_MAN'(s1_sum_q << s1_lz_q);
    assign unf_c     = ~s1_ovf_q & ~s1_zero_q & (CMP_W'(s1_lz_q) >= CMP_W'(s1_exp_q));

    always_comb begin
        o_valid_d = o_valid_q;
        o_sign_d  = o_sign_q;
        o_exp_d   = o_exp_q;
        o_lopd_d  = o_lopd_q;
        o_ovf_d   = o_ovf_q;
        o_unf_d   = o_unf_q;
        o_zero_d  = o_zero_q;
        o_mant_d  = o_mant_q;
        if (s2_adv) begin
            o_valid_d = s1_valid_q;
            o_sign_d  = s1_sign_q;
            o_exp_d   = s1_exp_q;
            o_lopd_d  = '0;
            o_ovf_d   = 1'b0;
            o_unf_d   = 1'b0;
            o_zero_d  = 1'b0;
            o_mant_d  = '0;
            if (s1_ovf_q) begin
                o_ovf_d  = 1'b1;
                o_mant_d = s1_sum_q[SIZE_SUM-2:1];
            end else if (s1_zero_q) begin
                o_zero_d = 1'b1;
            end else if (unf_c) begin
                o_unf_d  = 1'b1;
                o_zero_d = 1'b1;
            end else begin
                o_lopd_d = s1_lz_q;
                o_mant_d = norm_mant;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_valid_q <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_exp_q   <= '0;
            s1_sum_q   <= '0;
            s1_ovf_q   <= 1'b0;
            s1_zero_q  <= 1'b0;
            s1_lz_q    <= '0;
            o_valid_q  <= 1'b0;
            o_sign_q   <= 1'b0;
            o_exp_q    <= '0;
            o_lopd_q   <= '0;
            o_ovf_q    <= 1'b0;
            o_unf_q    <= 1'b0;
            o_zero_q   <= 1'b0;
            o_mant_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_sign_q  <= s1_sign_d;
            s1_exp_q   <= s1_exp_d;
            s1_sum_q   <= s1_sum_d;
            s1_ovf_q   <= s1_ovf_d;
            s1_zero_q  <= s1_zero_d;
            s1_lz_q    <= s1_lz_d;
            o_valid_q  <= o_valid_d;
            o_sign_q   <= o_sign_d;
            o_exp_q    <= o_exp_d;
            o_lopd_q   <= o_lopd_d;
            o_ovf_q    <= o_ovf_d;
            o_unf_q    <= o_unf_d;
            o_zero_q   <= o_zero_d;
            o_mant_q   <= o_mant_d;
        end
    end

    assign bus.o_valid      = o_valid_q;
    assign bus.o_sign       = o_sign_q;
    assign bus.o_exp_value  = o_exp_q;
    assign bus.o_lopd_value = o_lopd_q;
    assign bus.o_overflow   = o_ovf_q;
    assign bus.o_underflow  = o_unf_q;
    assign bus.o_zero_flag  = o_zero_q;
    assign bus.o_mant       = o_mant_q;

endmodule

// File: tb/tb_add_sub_mant_normalize.sv
// Scoreboard bench for add_sub_mant_normalize: random and directed stimulus,
// arithmetic reference model, decoupled output monitor.
module tb_add_sub_mant_normalize;
    import fpu_add_sub_pkg::*;

    logic i_clk = 1'b0;
    logic i_rst_n;
    always #5 i_clk = ~i_clk;

    add_sub_mant_normalize_if bus ();

    add_sub_mant_normalize dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus)
    );

    int           n_checks = 0;
    int           n_fail   = 0;
    int           n_txn    = 0;
    bit           rand_ready = 1'b0;
    norm_result_t exp_q[$];

    function automatic void check(string name, logic [63:0] act, logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, req);
        end
    endfunction

    function automatic norm_result_t mk(bit s, int e, int lopd, bit ovf, bit unf, bit z, int m);
        norm_result_t r;
        r.sign = s;
        r.exp = 8'(e);
        r.lopd = 8'(lopd);
        r.overflow = ovf;
        r.underflow = unf;
        r.zero = z;
        r.mant = 23'(m);
        return r;
    endfunction

    // Arithmetic view: scale the magnitude until it lies in [2^23, 2^24).
    function automatic norm_result_t model(bit s, logic [7:0] e, logic [24:0] sum);
        longint v = longint'(sum);
        int lz = 0;
        if (v >= (longint'(1) << 24))
            return mk(s, e, 0, 1, 0, 0, int'((v / 2) % (longint'(1) << 23)));
        if (v == 0)
            return mk(s, e, 0, 0, 0, 1, 0);
        while (v < (longint'(1) << 23)) begin
            v = v * 2;
            lz++;
        end
        if (lz >= int'(e))
            return mk(s, e, 0, 0, 1, 1, 0);
        return mk(s, e, lz, 0, 0, 0, int'(v - (longint'(1) << 23)));
    endfunction

    // Monitor: compare the presented result to the queue head every cycle it
    // is valid (so a stalled output must stay equal), pop on transfer.
    initial begin
        norm_result_t act;
        forever begin
            @(negedge i_clk);
            if (i_rst_n === 1'b1 && bus.o_valid === 1'b1) begin
                act = {bus.o_sign, bus.o_exp_value, bus.o_lopd_value, bus.o_overflow,
                       bus.o_underflow, bus.o_zero_flag, bus.o_mant};
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: actual %h required none", act);
                end else begin
                    check("result", 64'(act), 64'(exp_q[0]));
                    if (bus.i_ready === 1'b1) begin
                        void'(exp_q.pop_front());
                        n_txn++;
                        $display("txn %0d sign=%0b exp=%h lopd=%0d ovf=%0b unf=%0b zero=%0b mant=%h",
                                 n_txn, act.sign, act.exp, act.lopd, act.overflow,
                                 act.underflow, act.zero, act.mant);
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge i_clk);
            #1;
            if (rand_ready) bus.i_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic send(input bit s, input logic [7:0] e, input logic [24:0] sum,
                        input bit use_given, input norm_result_t given);
        bit done = 1'b0;
        bus.i_valid     = 1'b1;
        bus.i_sign      = s;
        bus.i_exp_value = e;
        bus.i_sum       = sum;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge i_clk);
            if (bus.o_ready === 1'b1) begin
                exp_q.push_back(use_given ? given : model(s, e, sum));
                @(posedge i_clk);
                #1;
                done = 1'b1;
            end
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: actual o_ready=%b required 1", bus.o_ready);
        end
    endtask

    task automatic idle();
        bus.i_valid = 1'b0;
        bus.i_sum   = 25'($urandom);
    endtask

    task automatic drain();
        for (int k = 0; k < 1000 && exp_q.size() != 0; k++) @(posedge i_clk);
        #1;
        check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic send_rand();
        logic [24:0] sum;
        logic [7:0]  e;
        case ($urandom_range(0, 9))
            0:       sum = '0;
            1:       sum = 25'd1 << $urandom_range(0, 22);
            2, 3:    sum = 25'h1000000 | 25'($urandom & 32'hFFFFFF);
            4:       sum = 25'($urandom_range(1, 255));
            default: sum = 25'($urandom & 32'hFFFFFF);
        endcase
        case ($urandom_range(0, 3))
            0:       e = 8'($urandom_range(0, 24));
            1:       e = 8'hFF;
            2:       e = 8'h00;
            default: e = 8'($urandom);
        endcase
        send(1'($urandom), e, sum, 1'b0, '0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        i_rst_n         = 1'b0;
        bus.i_valid     = 1'b0;
        bus.i_ready     = 1'b0;
        bus.i_sign      = 1'b0;
        bus.i_exp_value = '0;
        bus.i_sum       = '0;
        #2;
        check("reset_o_valid", 64'(bus.o_valid), 64'd0);
        check("reset_o_ready", 64'(bus.o_ready), 64'd1);
        check("reset_outputs", 64'({bus.o_sign, bus.o_exp_value, bus.o_lopd_value, bus.o_overflow,
                                    bus.o_underflow, bus.o_zero_flag, bus.o_mant}), 64'd0);
        #15;
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;

        // Directed cases with hand-derived expectations.
        bus.i_ready = 1'b1;
        send(1'b0, 8'h80, 25'h1800000, 1'b1, mk(0, 8'h80, 0, 1, 0, 0, 23'h400000));
        send(1'b0, 8'h85, 25'h0010000, 1'b1, mk(0, 8'h85, 7, 0, 0, 0, 0));
        send(1'b1, 8'h40, 25'h0000000, 1'b1, mk(1, 8'h40, 0, 0, 0, 1, 0));
        send(1'b0, 8'h05, 25'h0000001, 1'b1, mk(0, 8'h05, 0, 0, 1, 1, 0));
        send(1'b1, 8'hFF, 25'h1FFFFFF, 1'b1, mk(1, 8'hFF, 0, 1, 0, 0, 23'h7FFFFF));
        send(1'b0, 8'h00, 25'h0800000, 1'b1, mk(0, 8'h00, 0, 0, 1, 1, 0));
        send(1'b0, 8'h01, 25'h0800001, 1'b1, mk(0, 8'h01, 0, 0, 0, 0, 1));
        send(1'b0, 8'h02, 25'h0400003, 1'b1, mk(0, 8'h02, 1, 0, 0, 0, 6));
        idle();
        drain();

        // Backpressure: both stages fill, o_ready must drop, nothing lost.
        base = n_txn;
        fork
            begin
                for (int i = 0; i < 4; i++) send_rand();
                idle();
            end
            begin
                bus.i_ready = 1'b0;
                repeat (2) @(posedge i_clk);
                #1;
                check("o_ready_full", 64'(bus.o_ready), 64'd0);
                repeat (4) @(posedge i_clk);
                #1;
                bus.i_ready = 1'b1;
            end
        join
        drain();
        check("backpressure_count", 64'(n_txn - base), 64'd4);

        // Random traffic with random downstream stalls.
        rand_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            send_rand();
            if ($urandom_range(0, 4) == 0) begin
                idle();
                repeat ($urandom_range(1, 3)) @(posedge i_clk);
                #1;
            end
        end
        idle();
        drain();
        rand_ready = 1'b0;
        @(posedge i_clk);
        #1;

        // Asynchronous reset with two items in flight.
        bus.i_ready = 1'b0;
        send(1'b0, 8'h90, 25'h0123456, 1'b0, '0);
        send(1'b1, 8'h91, 25'h1234567, 1'b0, '0);
        idle();
        @(negedge i_clk);
        #2;
        i_rst_n = 1'b0;
        #1;
        check("async_reset_o_valid", 64'(bus.o_valid), 64'd0);
        exp_q.delete();
        @(posedge i_clk);
        #2;
        i_rst_n = 1'b1;
        bus.i_ready = 1'b1;
        #1;
        check("post_reset_o_ready", 64'(bus.o_ready), 64'd1);
        send(1'b0, 8'h7F, 25'h0200000, 1'b0, '0);
        idle();
        check("post_reset_latency1", 64'(bus.o_valid), 64'd0);
        @(posedge i_clk);
        #1;
        check("post_reset_latency2", 64'(bus.o_valid), 64'd1);
        drain();

        repeat (4) @(posedge i_clk);
        #1;
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/add_sub_mant_normalize.md
Name: add_sub_mant_normalize

Overview:
- Pipelined normalisation stage of the FPU add/sub datapath.
- Sits between the mantissa adder and the exponent-adjust stage.
- Takes the raw signed-magnitude mantissa sum plus the pre-aligned exponent, detects the leading one, and classifies the result as overflow, underflow or zero.
- Produces the shift amount, the flags, the normalised mantissa and the pass-through exponent and sign that exponent adjust and packing consume; valid/ready handshake on both sides.

Parameters:
- SIZE_EXP, 8, exponent width.
- SIZE_MAN, 23, stored fraction width; sum width SIZE_SUM = SIZE_MAN+2 (carry, hidden, fraction).
- SIZE_LOPD, 8, width of the leading-one shift amount; must be >= clog2(SIZE_SUM).

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset
- i_valid  in  1  upstream data valid
- o_ready  out  1  stage can accept
- i_sign  in  1  result sign from adder
- i_exp_value  in  SIZE_EXP  larger operand exponent
- i_sum  in  SIZE_SUM  mantissa sum magnitude
- o_valid  out  1  output data valid
- i_ready  in  1  downstream can accept
- o_sign  out  1  registered sign
- o_exp_value  out  SIZE_EXP  registered exponent, unmodified
- o_lopd_value  out  SIZE_LOPD  left-shift amount applied
- o_overflow  out  1  carry bit set, mantissa shifted right by 1
- o_underflow  out  1  required shift >= exponent; result flushed
- o_zero_flag  out  1  i_sum was zero or flushed
- o_mant  out  SIZE_MAN  normalised fraction, hidden bit removed

Behaviour:
- Reset: single clock i_clk; reset i_rst_n is asynchronous, active-low.
- Reset clears both stage valids and all output registers to 0; o_ready is 1 out of reset.
- Latency: 2 cycles from accepted input to o_valid; throughput 1 per cycle when i_ready=1.
- Handshake:
  - Transfer occurs when valid and ready are both high.
  - s2_adv = ~s2_valid | i_ready; s1_adv = ~s1_valid | s2_adv; o_ready = s1_adv.
  - o_ready is combinational from i_ready; this path is accepted.
  - Outputs hold stable while o_valid=1 and i_ready=0.
  - No bubble is inserted when both stages advance in the same cycle.
- Stage 1 (registered on s1_adv):
  - Captures sign, exp and sum.
  - Computes overflow = sum[SIZE_SUM-1].
  - Computes zero = (sum==0).
  - Computes lz = count of leading zeros of sum[SIZE_SUM-2:0] (0 when the hidden bit is set; don't-care when zero).
  - s1_valid <= i_valid when s1_adv.
- Stage 2 (registered on s2_adv):
  - Overflow: o_mant = sum[SIZE_SUM-2:1]; o_lopd_value = 0; o_underflow = 0. The dropped LSB is discarded; rounding is out of scope.
  - Zero: o_zero_flag = 1, o_mant = 0, o_lopd_value = 0, o_overflow = 0, o_underflow = 0.
  - Underflow (not zero, not overflow, lz >= exp): o_underflow = 1, o_zero_flag = 1, o_mant = 0, o_lopd_value = 0 (flush to zero; no denormal support).
  - Otherwise: o_mant = (sum << lz)[SIZE_SUM-3:0]; o_lopd_value = lz.
  - o_exp_value and o_sign pass through unchanged in all cases.
  - Overflow, underflow and zero are mutually exclusive by construction.
- Downstream contract: exponent adjust computes exp+1 on overflow, exp on underflow, exp-lopd otherwise.
- Exponent boundary:
  - No internal saturation.
  - Overflow with exp = all-ones passes through; downstream detects infinity.
- Reset mid-operation: in-flight data is discarded and o_valid drops to 0 asynchronously.

Decomposition:
- Shared package fpu_add_sub_pkg holds:
  - SIZE_EXP, SIZE_MAN and SIZE_SUM constants.
  - A normalise-result struct typedef (sign, exp, lopd, flags, mant) for reuse by the packing stage.
- One natural sub-module: add_sub_lopd, a combinational leading-one position detector (priority encoder on SIZE_SUM-1 bits, outputs count and all-zero flag).

Test Plan:
- Overflow: sum=25'h1800000, exp=8'h80, i_ready=1 -> after 2 cycles o_valid=1, o_overflow=1, o_lopd_value=0, o_mant=23'h400000, o_exp_value=8'h80.
- Normal left shift: sum=25'h0010000, exp=8'h85 -> o_lopd_value=7, o_mant=0, flags 0, o_exp_value=8'h85.
- Zero and underflow:
  - sum=0 -> o_zero_flag=1, o_mant=0, o_lopd_value=0.
  - sum=25'h0000001, exp=8'h05 -> o_underflow=1, o_zero_flag=1.
- Backpressure: stream 4 back-to-back inputs with i_ready=0 for cycles 3-6 -> o_ready falls once both stages are full, outputs hold stable, all 4 results emerge in order with none lost or duplicated.
- Async reset: assert i_rst_n=0 with 2 items in flight, between clock edges -> o_valid=0 immediately, o_ready=1 after release, and the first post-reset input appears 2 cycles after acceptance.
